// File: rtl/rc_sinc_ofifo_if.sv
// ---------------------------------------------------------------------------
// rc_sinc_ofifo_if
// Sample/stream bundle for the resampler output stage.
//   y_in    : 9-bit signed sample from the sinc resampler
//   y_vld   : one-cycle write strobe for y_in
//   m_data  : 8-bit signed head-of-FIFO sample
//   m_valid : m_data valid towards the consumer
//   m_ready : consumer accepts m_data when m_valid && m_ready
// Modports: master = resampler/consumer side, slave = the FIFO stage.
// ---------------------------------------------------------------------------
interface rc_sinc_ofifo_if;
    logic signed [8:0] y_in;
    logic              y_vld;
    logic signed [7:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output y_in,
        output y_vld,
        output m_ready,
        input  m_data,
        input  m_valid
    );

    modport slave (
        input  y_in,
        input  y_vld,
        input  m_ready,
        output m_data,
        output m_valid
    );
endinterface

// File: rtl/rc_sinc_ofifo.sv
// ---------------------------------------------------------------------------
// rc_sinc_ofifo
// Output stage behind the 3/4 rational sinc resampler. Saturates 9-bit
// samples to 8 bits, buffers them in a DEPTH-entry FIFO and presents them
// as a valid/ready stream. A FILL/STREAM machine withholds m_valid until
// PRIME samples are buffered and re-primes after an underrun.
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   s        : sample in / stream out bundle (rc_sinc_ofifo_if.slave)
//   clr      : synchronous clear of sticky flags and drop count
//   level    : FIFO occupancy, 0..DEPTH
//   sat      : sticky, an input sample was clipped
//   ovf      : sticky, a sample was dropped on a full FIFO
//   udr      : sticky, FIFO emptied while streaming
//   drop_cnt : dropped-sample count (saturating at 255)
//
// Build option: define RC_OFIFO_CNT_EN to build the drop counter;
// otherwise drop_cnt is tied to zero.
// ---------------------------------------------------------------------------
module rc_sinc_ofifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int PRIME = 2
) (
    input  logic                clk,
    input  logic                reset,
    rc_sinc_ofifo_if.slave      s,
    input  logic                clr,
    output logic [AW:0]         level,
    output logic                sat,
    output logic                ovf,
    output logic                udr,
    output logic [7:0]          drop_cnt
);

    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_LVL = (AW+1)'(PRIME);

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       level_q, level_d;
    logic signed [7:0] mem_q [DEPTH];
    logic              sat_q, ovf_q, udr_q;

    logic              clip_hi, clip_lo, clip;
    logic signed [7:0] y_sat;
    logic              m_valid_w, rd_fire, wr_ok, drop, udr_evt;

    // Saturation: 9-bit values whose top two bits differ do not fit in 8 bits.
    always_comb begin
        clip_hi = ~s.y_in[8] & s.y_in[7];
        clip_lo = s.y_in[8] & ~s.y_in[7];
        clip    = s.y_vld & (clip_hi | clip_lo);
        y_sat   = s.y_in[7:0];
        if (clip_hi) y_sat = 8'sd127;
        if (clip_lo) y_sat = -8'sd128;
    end

    // Handshake, occupancy and FSM next state.
    always_comb begin
        m_valid_w = (state_q == ST_STREAM) && (level_q != '0);
        rd_fire   = m_valid_w && s.m_ready;
        // A full FIFO still takes a write when a read frees a slot this cycle.
        wr_ok     = s.y_vld && ((level_q != FULL_LVL) || rd_fire);
        drop      = s.y_vld && !wr_ok;

        level_d = level_q;
        case ({wr_ok, rd_fire})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        state_d = state_q;
        udr_evt = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (level_d >= PRIME_LVL) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (rd_fire && !wr_ok && (level_d == '0)) begin
                    state_d = ST_FILL;
                    udr_evt = 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= y_sat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Sticky flags: an event in the clr cycle still sets its flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
            udr_q <= 1'b0;
        end else begin
            sat_q <= clip    | (sat_q & ~clr);
            ovf_q <= drop    | (ovf_q & ~clr);
            udr_q <= udr_evt | (udr_q & ~clr);
        end
    end

`ifdef RC_OFIFO_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : cnt_q;
        if (drop && (cnt_d != 8'hFF)) cnt_d = cnt_d + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign drop_cnt = cnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign s.m_data  = mem_q[rd_ptr_q];
    assign s.m_valid = m_valid_w;
    assign level     = level_q;
    assign sat       = sat_q;
    assign ovf       = ovf_q;
    assign udr       = udr_q;

endmodule

// File: tb/tb_rc_sinc_ofifo.sv
// ---------------------------------------------------------------------------
// tb_rc_sinc_ofifo
// Directed bench for rc_sinc_ofifo (DEPTH=8, PRIME=2). Inputs change and
// outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_rc_sinc_ofifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic [3:0] level;
    logic       sat, ovf, udr;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    rc_sinc_ofifo_if bus ();

    rc_sinc_ofifo #(
        .DEPTH (8),
        .AW    (3),
        .PRIME (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (bus),
        .clr      (clr),
        .level    (level),
        .sat      (sat),
        .ovf      (ovf),
        .udr      (udr),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int v);
        bus.y_in  = 9'(v);
        bus.y_vld = 1'b1;
        tick();
        bus.y_vld = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    int exp_sat [4] = '{127, -128, 127, -128};
    int exp_ovf [8] = '{2, 3, 4, 5, 6, 7, 8, 50};
    int exp_drop;
    int q [$];
    int got, gaps, k;
    bit primed;

    initial begin
        reset       = 1'b0;
        clr         = 1'b0;
        bus.y_in    = '0;
        bus.y_vld   = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        // Reset state
        chk("rst_level",   int'(level),       0);
        chk("rst_m_valid", int'(bus.m_valid), 0);
        chk("rst_m_data",  int'(bus.m_data),  0);
        chk("rst_flags",   int'({sat, ovf, udr}), 0);
        chk("rst_drop",    int'(drop_cnt),    0);

        // Saturation (-300 does not fit in 9 bits; -200 exercises the low clip)
        put(200);
        put(-200);
        put(127);
        put(-128);
        chk("sat_level", int'(level), 4);
        chk("sat_flag",  int'(sat),   1);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("sat_valid", int'(bus.m_valid), 1);
            chk("sat_data",  int'(bus.m_data),  exp_sat[i]);
            tick();
        end
        chk("sat_empty_valid", int'(bus.m_valid), 0);
        chk("sat_udr",         int'(udr),         1);
        chk("sat_ovf",         int'(ovf),         0);
        bus.m_ready = 1'b0;
        do_clr();
        chk("clr_sat", int'(sat), 0);
        chk("clr_udr", int'(udr), 0);

        // Prime / underrun with m_ready held high
        bus.m_ready = 1'b1;
        put(5);
        chk("prime1_valid", int'(bus.m_valid), 0);
        chk("prime1_level", int'(level),       1);
        put(6);
        chk("prime2_valid", int'(bus.m_valid), 1);
        chk("prime2_level", int'(level),       2);
        chk("prime2_data",  int'(bus.m_data),  5);
        tick();
        chk("drain1_data",  int'(bus.m_data),  6);
        chk("drain1_valid", int'(bus.m_valid), 1);
        tick();
        chk("udr_flag",  int'(udr),         1);
        chk("udr_valid", int'(bus.m_valid), 0);
        chk("udr_level", int'(level),       0);
        tick();
        chk("udr_idle_valid", int'(bus.m_valid), 0);
        put(7);
        chk("reprime1_valid", int'(bus.m_valid), 0);
        put(8);
        chk("reprime2_valid", int'(bus.m_valid), 1);
        chk("reprime2_data",  int'(bus.m_data),  7);
        tick();
        chk("reprime_drain_data", int'(bus.m_data), 8);
        tick();
        bus.m_ready = 1'b0;
        do_clr();

        // Overflow with m_ready low
`ifdef RC_OFIFO_CNT_EN
        exp_drop = 2;
`else
        exp_drop = 0;
`endif
        for (int v = 1; v <= 10; v++) put(v);
        chk("ovf_level", int'(level),    8);
        chk("ovf_flag",  int'(ovf),      1);
        chk("ovf_drop",  int'(drop_cnt), exp_drop);
        chk("ovf_head",  int'(bus.m_data), 1);
        do_clr();
        chk("ovf_clr_flag", int'(ovf),      0);
        chk("ovf_clr_drop", int'(drop_cnt), 0);

        // Full FIFO with simultaneous read and write
        bus.m_ready = 1'b1;
        put(50);
        chk("rw_full_level", int'(level),    8);
        chk("rw_full_ovf",   int'(ovf),      0);
        chk("rw_full_drop",  int'(drop_cnt), 0);
        for (int i = 0; i < 8; i++) begin
            chk("rw_drain_data", int'(bus.m_data), exp_ovf[i]);
            tick();
        end
        chk("rw_drain_level", int'(level), 0);
        bus.m_ready = 1'b0;
        do_clr();

        // Asynchronous reset mid-stream at level 5
        put(200);
        for (int v = 1; v <= 4; v++) put(v);
        chk("pre_rst_level", int'(level), 5);
        chk("pre_rst_sat",   int'(sat),   1);
        reset = 1'b0;
        #1;
        chk("async_rst_level", int'(level),       0);
        chk("async_rst_valid", int'(bus.m_valid), 0);
        chk("async_rst_data",  int'(bus.m_data),  0);
        chk("async_rst_sat",   int'(sat),         0);
        tick();
        reset = 1'b1;
        put(10);
        chk("post_rst_data",  int'(bus.m_data),  10);
        chk("post_rst_level", int'(level),       1);
        chk("post_rst_valid", int'(bus.m_valid), 0);

        // Rate check: bursts of 3 per 12 clocks, consumer 1 per 4 clocks
        reset = 1'b0;
        tick();
        reset = 1'b1;
        q.delete();
        got    = 0;
        gaps   = 0;
        primed = 1'b0;
        k      = 0;
        for (int c = 0; c < 1200; c++) begin
            bus.y_vld   = ((c % 12) < 3);
            bus.m_ready = ((c % 4) == 1);
            if (bus.y_vld) begin
                bus.y_in = 9'(((k * 37) % 256) - 128);
                q.push_back(((k * 37) % 256) - 128);
                k++;
            end
            if (bus.m_valid && bus.m_ready) begin
                chk("rate_data", int'(bus.m_data), q.pop_front());
                got++;
            end
            tick();
            if (bus.m_valid) primed = 1'b1;
            else if (primed) gaps++;
        end
        bus.y_vld   = 1'b0;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 50 && q.size() > 0; c++) begin
            if (bus.m_valid) begin
                chk("rate_drain_data", int'(bus.m_data), q.pop_front());
                got++;
            end
            tick();
        end
        chk("rate_ovf",       int'(ovf), 0);
        chk("rate_delivered", got,       300);
        chk("rate_gaps",      gaps,      0);
        chk("rate_leftover",  q.size(),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
